// File: rtl/box_plotter.sv
// Expands one box request into a BOX_W x BOX_H row-major run of pixel writes
// for the 160x120 VGA adapter, one pixel per clock, with off-screen clipping.
module box_plotter #(
  parameter int BOX_W = 3,
  parameter int BOX_H = 3,
  parameter int X_MAX = 160,
  parameter int Y_MAX = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic [2:0] req_colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t     r_state;
  logic [7:0] r_bx;
  logic [6:0] r_by;
  logic [2:0] r_dx;
  logic [2:0] r_dy;
  logic [7:0] r_vx;
  logic [6:0] r_vy;
  logic [2:0] r_vcol;
  logic       r_plot;
  logic       r_busy;
  logic       r_done;
  logic       r_ready;

  logic       w_row_end;
  logic       w_last;
  logic [2:0] w_ndx;
  logic [2:0] w_ndy;
  logic [8:0] w_px;
  logic [7:0] w_py;
  logic [8:0] w_ax;
  logic [7:0] w_ay;
  logic       w_accept;

  always_comb begin
    w_row_end = (r_dx == 3'(BOX_W - 1));
    w_last    = w_row_end && (r_dy == 3'(BOX_H - 1));
    w_ndx     = w_row_end ? '0 : r_dx + 3'd1;
    w_ndy     = w_row_end ? r_dy + 3'd1 : r_dy;
    w_px      = {1'b0, r_bx} + {6'd0, w_ndx};
    w_py      = {1'b0, r_by} + {5'd0, w_ndy};
    w_ax      = {1'b0, req_x};
    w_ay      = {1'b0, req_y};
    w_accept  = req_valid && r_ready && (r_state == S_IDLE);
  end

  // The first pixel is registered on the acceptance edge itself, so the
  // (dx,dy) registers track the pixel currently on the vga_* outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_bx    <= '0;
      r_by    <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_vx    <= '0;
      r_vy    <= '0;
      r_vcol  <= '0;
      r_plot  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_plot <= 1'b0;
          r_done <= 1'b0;
          if (w_accept) begin
            r_bx    <= req_x;
            r_by    <= req_y;
            r_dx    <= '0;
            r_dy    <= '0;
            r_vx    <= req_x;
            r_vy    <= req_y;
            r_vcol  <= req_colour;
            r_plot  <= (w_ax < 9'(X_MAX)) && (w_ay < 8'(Y_MAX));
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_state <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (w_last) begin
            r_plot  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_dx   <= w_ndx;
            r_dy   <= w_ndy;
            r_vx   <= w_px[7:0];
            r_vy   <= w_py[6:0];
            r_plot <= (w_px < 9'(X_MAX)) && (w_py < 8'(Y_MAX));
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_plot  <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign vga_x      = r_vx;
  assign vga_y      = r_vy;
  assign vga_colour = r_vcol;
  assign vga_plot   = r_plot;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_box_plotter.sv
// Directed bench for box_plotter: table of boxes with hand-computed pixel
// streams, plus back-to-back, mid-box reset and a 1x1 instance.
module tb_box_plotter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_x = '0;
  logic [6:0] req_y = '0;
  logic [2:0] req_colour = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_x = '0;
  logic [6:0] s_y = '0;
  logic [2:0] s_colour = '0;
  logic [7:0] s_vx;
  logic [6:0] s_vy;
  logic [2:0] s_vcol;
  logic       s_plot;
  logic       s_busy;
  logic       s_done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  box_plotter dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .done(done)
  );

  box_plotter #(.BOX_W(1), .BOX_H(1), .X_MAX(160), .Y_MAX(120)) dut_1x1 (
    .clk(clk), .resetn(resetn),
    .req_valid(s_valid), .req_ready(s_ready),
    .req_x(s_x), .req_y(s_y), .req_colour(s_colour),
    .vga_x(s_vx), .vga_y(s_vy), .vga_colour(s_vcol),
    .vga_plot(s_plot), .busy(s_busy), .done(s_done)
  );

  typedef struct {
    logic [7:0]       x;
    logic [6:0]       y;
    logic [2:0]       col;
    logic [0:8][7:0]  ex;
    logic [0:8][6:0]  ey;
    logic [0:8]       pm;
  } box_t;

  box_t boxes[4];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge with the block idle; returns just after the acceptance edge.
  task automatic accept(input int i);
    chk("ready_before_req", int'(req_ready), 1);
    req_valid  = 1'b1;
    req_x      = boxes[i].x;
    req_y      = boxes[i].y;
    req_colour = boxes[i].col;
    @(posedge clk);
  endtask

  // Checks the 9 pixels, the done cycle and the ready cycle; nxt>=0 presents the
  // next request right after acceptance so it is held through the whole box.
  task automatic body(input int i, input int nxt);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (nxt >= 0) begin
          req_x      = boxes[nxt].x;
          req_y      = boxes[nxt].y;
          req_colour = boxes[nxt].col;
        end else begin
          req_valid = 1'b0;
        end
      end
      chk($sformatf("b%0d_px%0d_x", i, k), int'(vga_x), int'(boxes[i].ex[k]));
      chk($sformatf("b%0d_px%0d_y", i, k), int'(vga_y), int'(boxes[i].ey[k]));
      chk($sformatf("b%0d_px%0d_plot", i, k), int'(vga_plot), int'(boxes[i].pm[k]));
      chk($sformatf("b%0d_px%0d_col", i, k), int'(vga_colour), int'(boxes[i].col));
      chk($sformatf("b%0d_px%0d_busy", i, k), int'(busy), 1);
      chk($sformatf("b%0d_px%0d_ready", i, k), int'(req_ready), 0);
      chk($sformatf("b%0d_px%0d_done", i, k), int'(done), 0);
    end
    @(negedge clk);
    chk($sformatf("b%0d_done", i), int'(done), 1);
    chk($sformatf("b%0d_done_plot", i), int'(vga_plot), 0);
    chk($sformatf("b%0d_done_busy", i), int'(busy), 1);
    chk($sformatf("b%0d_done_ready", i), int'(req_ready), 0);
    @(negedge clk);
    chk($sformatf("b%0d_rdy", i), int'(req_ready), 1);
    chk($sformatf("b%0d_rdy_done", i), int'(done), 0);
    chk($sformatf("b%0d_rdy_busy", i), int'(busy), 0);
    chk($sformatf("b%0d_rdy_plot", i), int'(vga_plot), 0);
  endtask

  initial begin
    boxes[0] = '{x: 8'd38, y: 7'd4, col: 3'b111,
                 ex: {8'd38, 8'd39, 8'd40, 8'd38, 8'd39, 8'd40, 8'd38, 8'd39, 8'd40},
                 ey: {7'd4, 7'd4, 7'd4, 7'd5, 7'd5, 7'd5, 7'd6, 7'd6, 7'd6},
                 pm: 9'b111_111_111};
    boxes[1] = '{x: 8'd158, y: 7'd118, col: 3'b100,
                 ex: {8'd158, 8'd159, 8'd160, 8'd158, 8'd159, 8'd160, 8'd158, 8'd159, 8'd160},
                 ey: {7'd118, 7'd118, 7'd118, 7'd119, 7'd119, 7'd119, 7'd120, 7'd120, 7'd120},
                 pm: 9'b110_110_000};
    boxes[2] = '{x: 8'd123, y: 7'd100, col: 3'b010,
                 ex: {8'd123, 8'd124, 8'd125, 8'd123, 8'd124, 8'd125, 8'd123, 8'd124, 8'd125},
                 ey: {7'd100, 7'd100, 7'd100, 7'd101, 7'd101, 7'd101, 7'd102, 7'd102, 7'd102},
                 pm: 9'b111_111_111};
    boxes[3] = '{x: 8'd254, y: 7'd126, col: 3'b101,
                 ex: {8'd254, 8'd255, 8'd0, 8'd254, 8'd255, 8'd0, 8'd254, 8'd255, 8'd0},
                 ey: {7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd0, 7'd0, 7'd0},
                 pm: 9'b000_000_000};

    // Reset then idle
    repeat (3) @(negedge clk);
    chk("rst_plot", int'(vga_plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_x", int'(vga_x), 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_ready", int'(req_ready), 1);
    chk("idle_plot", int'(vga_plot), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_y", int'(vga_y), 0);
    chk("idle_col", int'(vga_colour), 0);

    // Table of single boxes
    for (int i = 0; i < 4; i++) begin
      accept(i);
      body(i, -1);
    end

    // Back-to-back: second request held through box 0
    accept(0);
    body(0, 2);
    @(posedge clk);
    body(2, -1);
    @(negedge clk);
    chk("b2b_no_extra_plot", int'(vga_plot), 0);
    chk("b2b_still_ready", int'(req_ready), 1);

    // Reset after the 4th pixel of a box
    accept(0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    chk("pre_rst_px4_x", int'(vga_x), 38);
    chk("pre_rst_px4_y", int'(vga_y), 5);
    resetn = 1'b0;
    #1;
    chk("midrst_plot", int'(vga_plot), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_x", int'(vga_x), 0);
    chk("midrst_y", int'(vga_y), 0);
    chk("midrst_col", int'(vga_colour), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("postrst_no_done", int'(done), 0);
      chk("postrst_no_plot", int'(vga_plot), 0);
    end
    accept(0);
    body(0, -1);

    // 1x1 instance: plot at T+1, done at T+2, ready at T+3
    chk("s_ready0", int'(s_ready), 1);
    s_valid  = 1'b1;
    s_x      = 8'd0;
    s_y      = 7'd0;
    s_colour = 3'b001;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    chk("s_plot", int'(s_plot), 1);
    chk("s_x", int'(s_vx), 0);
    chk("s_y", int'(s_vy), 0);
    chk("s_col", int'(s_vcol), 1);
    chk("s_pix_done", int'(s_done), 0);
    @(negedge clk);
    chk("s_done", int'(s_done), 1);
    chk("s_done_plot", int'(s_plot), 0);
    chk("s_done_ready", int'(s_ready), 0);
    @(negedge clk);
    chk("s_ready", int'(s_ready), 1);
    chk("s_ready_done", int'(s_done), 0);
    chk("s_ready_busy", int'(s_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
